// File: rtl/read_handler_gen2.sv
// read_handler_gen2 -- read-side pointer/empty control for the dual-clock FIFO.
// This block does the following:
//   - brings the write gray pointer into rd_clk through a configurable synchroniser
//   - converts it to binary
//   - keeps the binary and gray read pointers
//   - produces registered empty, almost-empty and fill-level outputs
// Optional feature macro: RD_UNDERFLOW_EN
//   - defined: sticky underflow flag with a clear input
//   - undefined: rd_underflow is tied low and rd_underflow_clr is unused
module read_handler_gen2 #(
  parameter int ADDRSIZE      = 6,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                rd_en,
  input  logic [ADDRSIZE:0]   wr_ptr_gray,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rd_ptr,
  output logic                rd_empty,
  output logic                rd_aempty,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                rd_underflow,
  input  logic                rd_underflow_clr
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AEMPTY_LIM = PW'(AEMPTY_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] level_next;
  logic          pop;

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Write-pointer synchroniser chain; the last stage is the only one used downstream.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_gray = sync_q[SYNC_STAGES-1];
  assign wq_bin  = gray2bin(wq_gray);

  // Next-pointer and next-level arithmetic; modular subtraction keeps level right across wrap.
  always_comb begin
    pop          = rd_en & ~rd_empty;
    rd_bin_next  = rd_bin + {{(PW-1){1'b0}}, pop};
    rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;
    level_next   = wq_bin - rd_bin_next;
  end

  // Read pointer, RAM address and status registers, all updated from the next-state values.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin    <= '0;
      rd_addr   <= '0;
      rd_ptr    <= '0;
      rd_empty  <= 1'b1;
      rd_aempty <= 1'b1;
      rd_level  <= '0;
    end else begin
      rd_bin    <= rd_bin_next;
      rd_addr   <= rd_bin_next[ADDRSIZE-1:0];
      rd_ptr    <= rd_gray_next;
      rd_empty  <= (rd_gray_next == wq_gray);
      rd_aempty <= (level_next <= AEMPTY_LIM);
      rd_level  <= level_next;
    end
  end

`ifdef RD_UNDERFLOW_EN
  // Sticky underflow: a new underflow event takes priority over a clear in the same cycle.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_underflow <= 1'b0;
    end else if (rd_en & rd_empty) begin
      rd_underflow <= 1'b1;
    end else if (rd_underflow_clr) begin
      rd_underflow <= 1'b0;
    end
  end
`else
  logic unused_underflow_clr;

  // Underflow detection is compiled out; the clear input is kept only for port compatibility.
  assign unused_underflow_clr = rd_underflow_clr;
  assign rd_underflow         = 1'b0;
`endif

endmodule

// File: tb/tb_read_handler_gen2.sv
// tb_read_handler_gen2 -- directed bench for read_handler_gen2.
// ADDRSIZE=4, SYNC_STAGES=2, AEMPTY_THRESH=2.
// A queue-based FIFO model produces the expected outputs every cycle.
// Literal checks at the key points pin that model.
module tb_read_handler_gen2;

  localparam int ADDRSIZE = 4;
  localparam int SYNC     = 2;
  localparam int THRESH   = 2;
  localparam int PW       = ADDRSIZE + 1;
  localparam int PMOD     = 1 << PW;
  localparam int DEPTH    = 1 << ADDRSIZE;
`ifdef RD_UNDERFLOW_EN
  localparam int UF_EN = 1;
`else
  localparam int UF_EN = 0;
`endif

  logic                rd_clk = 1'b0;
  logic                rd_rst = 1'b1;
  logic                rd_en = 1'b0;
  logic [ADDRSIZE:0]   wr_ptr_gray = '0;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [ADDRSIZE:0]   rd_ptr;
  logic                rd_empty;
  logic                rd_aempty;
  logic [ADDRSIZE:0]   rd_level;
  logic                rd_underflow;
  logic                rd_underflow_clr = 1'b0;

  int checks = 0;
  int passed = 0;

  read_handler_gen2 #(
    .ADDRSIZE(ADDRSIZE),
    .SYNC_STAGES(SYNC),
    .AEMPTY_THRESH(THRESH)
  ) dut (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .rd_en(rd_en),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_addr(rd_addr),
    .rd_ptr(rd_ptr),
    .rd_empty(rd_empty),
    .rd_aempty(rd_aempty),
    .rd_level(rd_level),
    .rd_underflow(rd_underflow),
    .rd_underflow_clr(rd_underflow_clr)
  );

  always #5 rd_clk = ~rd_clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Set all inputs, then let the given number of falling edges pass.
  task automatic applyStimulus(input bit rst, input bit en, input bit clr,
                               input logic [ADDRSIZE:0] wg, input int cycles);
    rd_rst           = rst;
    rd_en            = en;
    rd_underflow_clr = clr;
    wr_ptr_gray      = wg;
    repeat (cycles) @(negedge rd_clk);
  endtask

  function automatic int g2b(input int g);
    int b = g;
    for (int s = 1; s < PW; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Behavioural model: a read count, a delay line of write counts, and derived flags.
  int m_rd = 0;
  int m_level = 0;
  int m_q[$];
  bit m_empty = 1'b1;
  bit m_aempty = 1'b1;
  bit m_uf = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge rd_clk) begin
    if (rd_rst) begin
      m_rd = 0;
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(0);
      m_level  = 0;
      m_empty  = 1'b1;
      m_aempty = 1'b1;
      m_uf     = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      int wq;
      bit was_empty;
      wq        = m_q[$];
      was_empty = m_empty;
      if (UF_EN != 0) begin
        if (rd_en && was_empty) m_uf = 1'b1;
        else if (rd_underflow_clr) m_uf = 1'b0;
      end
      if (rd_en && !was_empty) m_rd = (m_rd + 1) % PMOD;
      m_level  = (wq - m_rd + PMOD) % PMOD;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= THRESH);
      m_q.push_front(g2b(int'(wr_ptr_gray)));
      void'(m_q.pop_back());
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the rising edge.
  always @(negedge rd_clk) begin
    if (m_valid) begin
      checkOutput("m_addr", int'(rd_addr), m_rd % DEPTH);
      checkOutput("m_ptr", int'(rd_ptr), m_rd ^ (m_rd >> 1));
      checkOutput("m_empty", int'(rd_empty), int'(m_empty));
      checkOutput("m_aempty", int'(rd_aempty), int'(m_aempty));
      checkOutput("m_level", int'(rd_level), m_level);
      checkOutput("m_underflow", int'(rd_underflow), int'(m_uf));
    end
  end

  initial begin
    int exp_addr[6]   = '{1, 2, 3, 4, 5, 5};
    int exp_level[6]  = '{4, 3, 2, 1, 0, 0};
    int exp_aempty[6] = '{0, 0, 1, 1, 1, 1};
    int exp_empty[6]  = '{0, 0, 0, 0, 1, 1};
    int exp_wrap[3]   = '{15, 0, 1};

    // Reset held for two cycles.
    applyStimulus(1, 0, 0, 5'b00000, 2);
    checkOutput("rst_addr", int'(rd_addr), 0);
    checkOutput("rst_ptr", int'(rd_ptr), 0);
    checkOutput("rst_empty", int'(rd_empty), 1);
    checkOutput("rst_aempty", int'(rd_aempty), 1);
    checkOutput("rst_level", int'(rd_level), 0);
    checkOutput("rst_underflow", int'(rd_underflow), 0);

    // Fill to 5 entries; visible only on the third edge.
    applyStimulus(0, 0, 0, 5'b00111, 2);
    checkOutput("fill_e2_empty", int'(rd_empty), 1);
    checkOutput("fill_e2_level", int'(rd_level), 0);
    applyStimulus(0, 0, 0, 5'b00111, 1);
    checkOutput("fill_e3_empty", int'(rd_empty), 0);
    checkOutput("fill_e3_level", int'(rd_level), 5);
    checkOutput("fill_e3_aempty", int'(rd_aempty), 0);

    // Drain with six requests; the sixth hits an empty FIFO.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 5'b00111, 1);
      checkOutput("drain_addr", int'(rd_addr), exp_addr[i]);
      checkOutput("drain_level", int'(rd_level), exp_level[i]);
      checkOutput("drain_aempty", int'(rd_aempty), exp_aempty[i]);
      checkOutput("drain_empty", int'(rd_empty), exp_empty[i]);
    end
    checkOutput("drain_underflow", int'(rd_underflow), UF_EN);

    // Underflow clear, then clear colliding with a new underflow.
    applyStimulus(0, 0, 1, 5'b00111, 1);
    checkOutput("uf_clear", int'(rd_underflow), 0);
    applyStimulus(0, 1, 1, 5'b00111, 1);
    checkOutput("uf_set_wins", int'(rd_underflow), UF_EN);

    // Advance the read pointer to 30 by writing up to binary 30 and draining.
    applyStimulus(0, 1, 0, 5'b10001, 40);
    checkOutput("pre_wrap_addr", int'(rd_addr), 14);
    checkOutput("pre_wrap_ptr", int'(rd_ptr), 5'b10001);
    checkOutput("pre_wrap_empty", int'(rd_empty), 1);

    // Write pointer wraps to binary 1: three entries across the wrap.
    applyStimulus(0, 0, 1, 5'b00001, 3);
    checkOutput("wrap_level", int'(rd_level), 3);
    checkOutput("wrap_empty", int'(rd_empty), 0);
    checkOutput("wrap_underflow", int'(rd_underflow), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 5'b00001, 1);
      checkOutput("wrap_addr", int'(rd_addr), exp_wrap[i]);
    end
    checkOutput("wrap_ptr", int'(rd_ptr), 5'b00001);
    checkOutput("wrap_end_empty", int'(rd_empty), 1);
    checkOutput("wrap_end_level", int'(rd_level), 0);

    // Mid-operation reset with six entries outstanding; rd_en high must not matter.
    applyStimulus(0, 0, 0, 5'b00100, 3);
    checkOutput("mid_pre_level", int'(rd_level), 6);
    applyStimulus(1, 1, 0, 5'b00101, 1);
    checkOutput("mid_rst_addr", int'(rd_addr), 0);
    checkOutput("mid_rst_ptr", int'(rd_ptr), 0);
    checkOutput("mid_rst_empty", int'(rd_empty), 1);
    checkOutput("mid_rst_aempty", int'(rd_aempty), 1);
    checkOutput("mid_rst_level", int'(rd_level), 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 5'b00101, 1);
      checkOutput("mid_sync_empty", int'(rd_empty), 1);
      checkOutput("mid_sync_level", int'(rd_level), 0);
    end
    applyStimulus(0, 0, 0, 5'b00101, 1);
    checkOutput("mid_post_level", int'(rd_level), 6);
    checkOutput("mid_post_empty", int'(rd_empty), 0);
    checkOutput("mid_post_aempty", int'(rd_aempty), 0);

    applyStimulus(0, 0, 0, 5'b00101, 2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
